reg_seq_ctrl: RTL and testbench



---
 rtl/reg_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_reg_seq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_seq_ctrl.sv
// Multicycle sequencer in front of the 4x8 register file: fetch, decode, ADD/SUB/LDI, write-back.
// Optional build macro SAT_EN: ADD saturates at all-ones and SUB saturates at zero.
module reg_seq_ctrl #(
    parameter int unsigned PC_W   = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [DATA_W-1:0] INSTR,
    output logic [PC_W-1:0]   PC,
    input  logic [DATA_W-1:0] RD1,
    input  logic [DATA_W-1:0] RD2,
    output logic [1:0]        RA1,
    output logic [1:0]        RA2,
    output logic [1:0]        RA3,
    output logic [DATA_W-1:0] WD3,
    output logic              WE3,
    output logic              BUSY,
    output logic              HALTED,
    output logic              ZERO
);

    localparam logic [1:0] OP_LDI  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_IMM,
        S_WB,
        S_HALT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_nxt;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] ir_nxt;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] result_nxt;
    logic              zero_q;
    logic              zero_nxt;
    logic              we3_q;
    logic              busy_q;
    logic              halted_q;

    logic [DATA_W-1:0] add_res;
    logic [DATA_W-1:0] sub_res;

`ifdef SAT_EN
    // Carry/borrow out of the extended result selects the clamp value.
    logic [DATA_W:0] add_ext;
    logic [DATA_W:0] sub_ext;

    always_comb begin
        add_ext = {1'b0, RD1} + {1'b0, RD2};
        sub_ext = {1'b0, RD1} - {1'b0, RD2};
        add_res = add_ext[DATA_W] ? {DATA_W{1'b1}} : add_ext[DATA_W-1:0];
        sub_res = sub_ext[DATA_W] ? {DATA_W{1'b0}} : sub_ext[DATA_W-1:0];
    end
`else
    assign add_res = RD1 + RD2;
    assign sub_res = RD1 - RD2;
`endif

    // Next-state and datapath update decisions.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc_q;
        ir_nxt     = ir_q;
        result_nxt = result_q;
        zero_nxt   = zero_q;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = '0;
                end
            end
            S_FETCH: begin
                ir_nxt    = INSTR;
                pc_nxt    = pc_q + PC_W'(1);
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (ir_q[7:6] == OP_HALT) begin
                    state_nxt = S_HALT;
                end else if (ir_q[7:6] == OP_LDI) begin
                    state_nxt = S_IMM;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                result_nxt = ir_q[6] ? sub_res : add_res;
                zero_nxt   = (result_nxt == '0);
                state_nxt  = S_WB;
            end
            S_IMM: begin
                result_nxt = INSTR;
                pc_nxt     = pc_q + PC_W'(1);
                state_nxt  = S_WB;
            end
            S_WB: begin
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                if (START) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; status strobes are flopped from the next state so they never glitch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            we3_q    <= 1'b1;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_q     <= pc_nxt;
            ir_q     <= ir_nxt;
            result_q <= result_nxt;
            zero_q   <= zero_nxt;
            we3_q    <= (state_nxt != S_WB);
            busy_q   <= !(state_nxt inside {S_IDLE, S_HALT});
            halted_q <= (state_nxt == S_HALT);
        end
    end

    assign PC     = pc_q;
    assign RA1    = ir_q[3:2];
    assign RA2    = ir_q[1:0];
    assign RA3    = ir_q[5:4];
    assign WD3    = result_q;
    assign WE3    = we3_q;
    assign BUSY   = busy_q;
    assign HALTED = halted_q;
    assign ZERO   = zero_q;

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Bench for reg_seq_ctrl: bench-side ROM and register file, ISA-level model, per-cycle compare.
module tb_reg_seq_ctrl;

    localparam int unsigned PC_W     = 4;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned S_PC_W   = 2;
    localparam int unsigned ROM_D    = 1 << PC_W;
    localparam int unsigned S_ROM_D  = 1 << S_PC_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic [7:0]        instr;
    logic [PC_W-1:0]   pc;
    logic [7:0]        rd1, rd2, wd3;
    logic [1:0]        ra1, ra2, ra3;
    logic              we3, busy, halted, zero;

    logic              s_start;
    logic [7:0]        s_instr;
    logic [S_PC_W-1:0] s_pc;
    logic [7:0]        s_rd1, s_rd2, s_wd3;
    logic [1:0]        s_ra1, s_ra2, s_ra3;
    logic              s_we3, s_busy, s_halted, s_zero;

    logic [7:0] rom    [ROM_D];
    logic [7:0] regs   [4] = '{default: 8'h00};
    logic [7:0] s_rom  [S_ROM_D];
    logic [7:0] s_regs [4] = '{default: 8'h00};

    assign instr   = rom[pc];
    assign rd1     = regs[ra1];
    assign rd2     = regs[ra2];
    assign s_instr = s_rom[s_pc];
    assign s_rd1   = s_regs[s_ra1];
    assign s_rd2   = s_regs[s_ra2];

    always @(posedge clk) if (!we3) regs[ra3] <= wd3;
    always @(posedge clk) if (!s_we3) s_regs[s_ra3] <= s_wd3;

    reg_seq_ctrl #(.PC_W(PC_W), .DATA_W(DATA_W)) u_dut (
        .CLK(clk), .RST(rst), .START(start), .INSTR(instr), .PC(pc),
        .RD1(rd1), .RD2(rd2), .RA1(ra1), .RA2(ra2), .RA3(ra3),
        .WD3(wd3), .WE3(we3), .BUSY(busy), .HALTED(halted), .ZERO(zero)
    );

    reg_seq_ctrl #(.PC_W(S_PC_W), .DATA_W(DATA_W)) u_small (
        .CLK(clk), .RST(rst), .START(s_start), .INSTR(s_instr), .PC(s_pc),
        .RD1(s_rd1), .RD2(s_rd2), .RA1(s_ra1), .RA2(s_ra2), .RA3(s_ra3),
        .WD3(s_wd3), .WE3(s_we3), .BUSY(s_busy), .HALTED(s_halted), .ZERO(s_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] ra;
        logic [7:0] wd;
        logic       z;
    } wr_t;

    wr_t             exp_q[$];
    int              halt_cyc = 1000;
    logic [PC_W-1:0] exp_pc_halt = '0;
    logic [7:0]      m_regs [4] = '{default: 8'h00};
    logic            m_zero = 1'b0;
    logic [7:0]      prog[$];
    int              n_chk = 0;
    int              n_fail = 0;
    bit              run_active = 1'b0;
    int              cyc = 0;
    logic            exp_wr_now;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] alu(input logic is_sub, input logic [7:0] a, input logic [7:0] b);
        int r;
        r = is_sub ? (int'(a) - int'(b)) : (int'(a) + int'(b));
`ifdef SAT_EN
        if (r > 255) r = 255;
        if (r < 0) r = 0;
`endif
        return 8'(r & 255);
    endfunction

    // Execute the ROM image at instruction level; each ALU/LDI instruction is four cycles,
    // HALT is entered two cycles after its fetch.
    task automatic build_model();
        int         p = 0;
        int         c = 0;
        bit         done = 1'b0;
        logic [7:0] ir;
        logic [7:0] v;
        wr_t        w;
        exp_q.delete();
        halt_cyc = 1000;
        for (int n = 0; n < 32 && !done; n++) begin
            ir = rom[p];
            p  = (p + 1) % ROM_D;
            if (ir[7:6] == 2'b11) begin
                halt_cyc    = c + 2;
                exp_pc_halt = PC_W'(p);
                done        = 1'b1;
            end else begin
                if (ir[7:6] == 2'b10) begin
                    v = rom[p];
                    p = (p + 1) % ROM_D;
                end else begin
                    v      = alu(ir[6], m_regs[ir[3:2]], m_regs[ir[1:0]]);
                    m_zero = (v == 8'h00);
                end
                m_regs[ir[5:4]] = v;
                w.cyc = c + 3;
                w.ra  = ir[5:4];
                w.wd  = v;
                w.z   = m_zero;
                exp_q.push_back(w);
                c += 4;
            end
        end
    endtask

    always @(negedge clk) begin
        if (run_active) begin
            exp_wr_now = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("busy", 32'(busy), 32'(cyc < halt_cyc));
            chk("halted", 32'(halted), 32'(cyc >= halt_cyc));
            chk("we3", 32'(we3), 32'(!exp_wr_now));
            if (exp_wr_now) begin
                chk("ra3", 32'(ra3), 32'(exp_q[0].ra));
                chk("wd3", 32'(wd3), 32'(exp_q[0].wd));
                chk("zero", 32'(zero), 32'(exp_q[0].z));
                void'(exp_q.pop_front());
            end
            if (cyc >= halt_cyc) chk("pc_halt", 32'(pc), 32'(exp_pc_halt));
            cyc++;
        end
    end

    task automatic load_prog();
        foreach (rom[i]) rom[i] = 8'hC0;
        for (int i = 0; i < prog.size(); i++) rom[i] = prog[i];
    endtask

    task automatic run_prog(input int hold);
        build_model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("start_pc", 32'(pc), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_halted", 32'(halted), 32'd0);
        cyc        = 0;
        run_active = 1'b1;
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
        end
        start = 1'b0;
        while (cyc <= halt_cyc + 1) @(negedge clk);
        #1;
        run_active = 1'b0;
        chk("writes_done", 32'(exp_q.size()), 32'd0);
    endtask

    logic [1:0] s_exp_ra [3] = '{2'd3, 2'd1, 2'd2};
    logic [7:0] s_exp_wd [3] = '{8'h00, 8'h11, 8'h35};
    logic [7:0] old_r2;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        s_start = 1'b0;
        foreach (rom[i]) rom[i] = 8'hC0;
        foreach (s_rom[i]) s_rom[i] = 8'hC0;
        #12;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_we3", 32'(we3), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_ra1", 32'(ra1), 32'd0);
        chk("rst_ra2", 32'(ra2), 32'd0);
        chk("rst_ra3", 32'(ra3), 32'd0);
        chk("rst_wd3", 32'(wd3), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Two-bit PC: LDI at address 3 takes its immediate from address 0; START held high throughout.
        s_rom[0] = 8'h35;
        s_rom[1] = 8'h90;
        s_rom[2] = 8'h11;
        s_rom[3] = 8'hA0;
        @(negedge clk);
        s_start = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("s_busy", 32'(s_busy), 32'd1);
            chk("s_we3", 32'(s_we3), 32'((c % 4) != 3));
            if ((c % 4) == 3) begin
                chk("s_ra3", 32'(s_ra3), 32'(s_exp_ra[c / 4]));
                chk("s_wd3", 32'(s_wd3), 32'(s_exp_wd[c / 4]));
            end
            if (c == 11) chk("s_pc_wrap", 32'(s_pc), 32'd1);
        end
        s_start = 1'b0;

        prog = '{8'h90, 8'h05, 8'hA0, 8'h07, 8'h06, 8'hC0};
        load_prog();
        run_prog(0);
        chk("p1_r0", 32'(regs[0]), 32'h0C);
        chk("p1_r1", 32'(regs[1]), 32'h05);
        chk("p1_r2", 32'(regs[2]), 32'h07);
        chk("p1_pc", 32'(pc), 32'd6);
        chk("p1_halted", 32'(halted), 32'd1);

        // Restart from HALT with START held into the busy cycles.
        run_prog(3);
        chk("p1b_r0", 32'(regs[0]), 32'h0C);
        chk("p1b_pc", 32'(pc), 32'd6);

        prog = '{8'h90, 8'h03, 8'hA0, 8'h05, 8'h76, 8'hC0};
        load_prog();
        run_prog(0);
`ifdef SAT_EN
        chk("sub_r3", 32'(regs[3]), 32'h00);
        chk("sub_zero", 32'(zero), 32'd1);
`else
        chk("sub_r3", 32'(regs[3]), 32'hFE);
        chk("sub_zero", 32'(zero), 32'd0);
`endif
        chk("sub_pc", 32'(pc), 32'd6);

        prog = '{8'h90, 8'h80, 8'h05, 8'hC0};
        load_prog();
        run_prog(0);
`ifdef SAT_EN
        chk("add_r0", 32'(regs[0]), 32'hFF);
        chk("add_zero", 32'(zero), 32'd0);
`else
        chk("add_r0", 32'(regs[0]), 32'h00);
        chk("add_zero", 32'(zero), 32'd1);
`endif
        chk("add_pc", 32'(pc), 32'd4);

        // Reset asserted in the middle of a write-back cycle must suppress the write.
        prog = '{8'hA0, 8'h5A, 8'hC0};
        load_prog();
        old_r2 = regs[2];
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 8 && we3; i++) @(negedge clk);
        chk("rst_wb_seen", 32'(we3), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_wb_we3", 32'(we3), 32'd1);
        chk("rst_wb_busy", 32'(busy), 32'd0);
        chk("rst_wb_halted", 32'(halted), 32'd0);
        chk("rst_wb_pc", 32'(pc), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_wb_nowrite", 32'(regs[2]), 32'(old_r2));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_pc", 32'(pc), 32'd0);
        chk("idle_we3", 32'(we3), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
